// File: rtl/pipeline_stall_ctrl.sv
// Hazard and stall sequencer for the 5-stage pipeline: load-use stalls, branch
// flushes, and variable-latency data-memory waits with a timeout into a sticky error.
module pipeline_stall_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             IDEX_MemRead_i,
    input  logic [4:0]       IDEX_RDaddr_i,
    input  logic [4:0]       IFID_RS1addr_i,
    input  logic [4:0]       IFID_RS2addr_i,
    input  logic             Branch_taken_i,
    input  logic             EXMEM_MemRead_i,
    input  logic             EXMEM_MemWrite_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             PCWrite_o,
    output logic             IFID_Write_o,
    output logic             IFID_Flush_o,
    output logic             IDEX_Bubble_o,
    output logic             EXMEM_Write_o,
    output logic             MEMWB_Write_o,
    output logic             MEMWB_Bubble_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [1:0]       state_o
);

    localparam int TW = $clog2(MEM_TIMEOUT) + 1;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] tcnt;
    logic [TW-1:0] tcnt_nxt;
    logic          err_nxt;

    logic mem_access;
    logic loaduse;
    logic advance;
    logic freeze;

    assign mem_access = EXMEM_MemRead_i | EXMEM_MemWrite_i;
    assign loaduse    = IDEX_MemRead_i && (IDEX_RDaddr_i != 5'd0) &&
                        ((IDEX_RDaddr_i == IFID_RS1addr_i) ||
                         (IDEX_RDaddr_i == IFID_RS2addr_i));

    // A pending memory access without ack freezes everything; an ack in
    // MEM_WAIT makes the cycle behave exactly like a zero-wait RUN cycle.
    always_comb begin
        advance = 1'b0;
        freeze  = 1'b0;
        case (state)
            RUN: begin
                advance = !mem_access || mem_ack_i;
                freeze  = mem_access && !mem_ack_i;
            end
            MEM_WAIT: begin
                advance = mem_ack_i;
                freeze  = !mem_ack_i;
            end
            default: begin
                advance = 1'b0;
                freeze  = 1'b0;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= RUN;
            tcnt      <= '0;
            mem_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            tcnt      <= tcnt_nxt;
            mem_err_o <= err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        tcnt_nxt  = tcnt;
        err_nxt   = mem_err_o;
        case (state)
            RUN: begin
                if (mem_access && !mem_ack_i) begin
                    state_nxt = MEM_WAIT;
                    tcnt_nxt  = TW'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack_i) begin
                    state_nxt = RUN;
                    tcnt_nxt  = '0;
                end else if (tcnt == TW'(MEM_TIMEOUT - 1)) begin
                    state_nxt = ERROR;
                    err_nxt   = 1'b1;
                end else begin
                    tcnt_nxt = tcnt + TW'(1);
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = RUN;
                tcnt_nxt  = '0;
            end
        endcase
    end

    // Output logic; the default is the ERROR pattern (everything held, MEM/WB bubbled)
    always_comb begin
        mem_req_o      = 1'b0;
        PCWrite_o      = 1'b0;
        IFID_Write_o   = 1'b0;
        IFID_Flush_o   = 1'b0;
        IDEX_Bubble_o  = 1'b0;
        EXMEM_Write_o  = 1'b0;
        MEMWB_Write_o  = 1'b0;
        MEMWB_Bubble_o = 1'b1;
        if (advance) begin
            mem_req_o      = mem_access;
            PCWrite_o      = 1'b1;
            IFID_Write_o   = 1'b1;
            EXMEM_Write_o  = 1'b1;
            MEMWB_Write_o  = 1'b1;
            MEMWB_Bubble_o = 1'b0;
            if (loaduse) begin
                PCWrite_o     = 1'b0;
                IFID_Write_o  = 1'b0;
                IDEX_Bubble_o = 1'b1;
            end else if (Branch_taken_i) begin
                IFID_Flush_o = 1'b1;
            end
        end else if (freeze) begin
            mem_req_o      = 1'b1;
            MEMWB_Write_o  = 1'b1;
            MEMWB_Bubble_o = 1'b1;
        end
    end

    // Saturating performance counter of cycles in which the PC is held
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= '0;
        end else if (!PCWrite_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
            stall_cnt_o <= stall_cnt_o + CNT_W'(1);
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed bench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=4): expected output
// vectors are queued as each step is driven and compared mid-cycle.
module tb_pipeline_stall_ctrl;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_MW  = 2'd1;
    localparam logic [1:0] S_ERR = 2'd2;

    // {mem_req, PCWrite, IFID_Write, IFID_Flush, IDEX_Bubble, EXMEM_Write, MEMWB_Write, MEMWB_Bubble}
    localparam logic [7:0] C_ADV     = 8'b0110_0110;
    localparam logic [7:0] C_ADV_REQ = 8'b1110_0110;
    localparam logic [7:0] C_LU      = 8'b0000_1110;
    localparam logic [7:0] C_BR      = 8'b0111_0110;
    localparam logic [7:0] C_BR_REQ  = 8'b1111_0110;
    localparam logic [7:0] C_FRZ     = 8'b1000_0011;
    localparam logic [7:0] C_ERR     = 8'b0000_0001;

    logic       clk = 1'b0;
    logic       rst;
    logic       idex_memread;
    logic [4:0] idex_rd;
    logic [4:0] ifid_rs1;
    logic [4:0] ifid_rs2;
    logic       branch_taken;
    logic       exmem_memread;
    logic       exmem_memwrite;
    logic       mem_ack;
    logic       mem_req;
    logic       pc_write;
    logic       ifid_write;
    logic       ifid_flush;
    logic       idex_bubble;
    logic       exmem_write;
    logic       memwb_write;
    logic       memwb_bubble;
    logic       mem_err;
    logic [3:0] stall_cnt;
    logic [1:0] state;

    logic [14:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .IDEX_MemRead_i  (idex_memread),
        .IDEX_RDaddr_i   (idex_rd),
        .IFID_RS1addr_i  (ifid_rs1),
        .IFID_RS2addr_i  (ifid_rs2),
        .Branch_taken_i  (branch_taken),
        .EXMEM_MemRead_i (exmem_memread),
        .EXMEM_MemWrite_i(exmem_memwrite),
        .mem_ack_i       (mem_ack),
        .mem_req_o       (mem_req),
        .PCWrite_o       (pc_write),
        .IFID_Write_o    (ifid_write),
        .IFID_Flush_o    (ifid_flush),
        .IDEX_Bubble_o   (idex_bubble),
        .EXMEM_Write_o   (exmem_write),
        .MEMWB_Write_o   (memwb_write),
        .MEMWB_Bubble_o  (memwb_bubble),
        .mem_err_o       (mem_err),
        .stall_cnt_o     (stall_cnt),
        .state_o         (state)
    );

    function automatic logic [14:0] vec(input logic [7:0] c, input logic e,
                                        input logic [1:0] s, input int n);
        return {c, e, s, 4'(n)};
    endfunction

    // Inputs change on the falling edge; outputs are sampled 2 ns later.
    task automatic step(input string tag, input logic r, input logic ld,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic br, input logic mr, input logic mw, input logic ack,
                        input logic [14:0] exp);
        logic [14:0] got;
        logic [14:0] want;
        @(negedge clk);
        rst            = r;
        idex_memread   = ld;
        idex_rd        = rd;
        ifid_rs1       = rs1;
        ifid_rs2       = rs2;
        branch_taken   = br;
        exmem_memread  = mr;
        exmem_memwrite = mw;
        mem_ack        = ack;
        exp_q.push_back(exp);
        #2;
        got  = {mem_req, pc_write, ifid_write, ifid_flush, idex_bubble, exmem_write,
                memwb_write, memwb_bubble, mem_err, state, stall_cnt};
        want = exp_q.pop_front();
        checks++;
        assert (got === want)
        else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, got, want);
        end
    endtask

    initial begin
        rst            = 1'b1;
        idex_memread   = 1'b0;
        idex_rd        = 5'd0;
        ifid_rs1       = 5'd0;
        ifid_rs2       = 5'd0;
        branch_taken   = 1'b0;
        exmem_memread  = 1'b0;
        exmem_memwrite = 1'b0;
        mem_ack        = 1'b0;
        @(posedge clk);

        step("reset_state", 1, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 0));

        // load-use on rs2, then x0 destination, then rs1
        step("loaduse_rs2",  0, 1, 5, 0, 5, 0, 0, 0, 0, vec(C_LU,  0, S_RUN, 0));
        step("after_lu_cnt", 0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 1));
        step("x0_no_stall",  0, 1, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 1));
        step("loaduse_rs1",  0, 1, 7, 7, 3, 0, 0, 0, 0, vec(C_LU,  0, S_RUN, 1));

        // branch flush, and load-use taking priority over the branch
        step("branch_flush", 0, 0, 0, 0, 0, 1, 0, 0, 0, vec(C_BR,  0, S_RUN, 2));
        step("lu_over_br",   0, 1, 3, 3, 0, 1, 0, 0, 0, vec(C_LU,  0, S_RUN, 2));
        step("br_reeval",    0, 0, 3, 3, 0, 1, 0, 0, 0, vec(C_BR,  0, S_RUN, 3));

        // zero-wait load, stray ack ignored
        step("zero_wait",    0, 0, 0, 0, 0, 0, 1, 0, 1, vec(C_ADV_REQ, 0, S_RUN, 3));
        step("zw_stay_run",  0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 3));
        step("stray_ack",    0, 0, 0, 0, 0, 0, 0, 0, 1, vec(C_ADV, 0, S_RUN, 3));

        // store acked after 3 frozen cycles; freeze overrides load-use and branch
        step("rst_hold_cnt", 1, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 3));
        step("st_wait1",     0, 0, 0, 0, 0, 0, 0, 1, 0, vec(C_FRZ, 0, S_RUN, 0));
        step("st_wait2_ovr", 0, 1, 4, 4, 0, 1, 0, 1, 0, vec(C_FRZ, 0, S_MW,  1));
        step("st_wait3",     0, 0, 0, 0, 0, 0, 0, 1, 0, vec(C_FRZ, 0, S_MW,  2));
        step("st_ack_br",    0, 0, 0, 0, 0, 1, 0, 1, 1, vec(C_BR_REQ, 0, S_MW, 3));
        step("st_done",      0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 3));

        // timeout into ERROR, sticky until reset
        step("to_rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 3));
        step("to_wait1",     0, 0, 0, 0, 0, 0, 1, 0, 0, vec(C_FRZ, 0, S_RUN, 0));
        step("to_wait2",     0, 0, 0, 0, 0, 0, 1, 0, 0, vec(C_FRZ, 0, S_MW,  1));
        step("to_wait3",     0, 0, 0, 0, 0, 0, 1, 0, 0, vec(C_FRZ, 0, S_MW,  2));
        step("to_wait4",     0, 0, 0, 0, 0, 0, 1, 0, 0, vec(C_FRZ, 0, S_MW,  3));
        step("err_enter",    0, 0, 0, 0, 0, 0, 1, 0, 1, vec(C_ERR, 1, S_ERR, 4));
        step("err_sticky",   0, 1, 2, 2, 0, 1, 0, 0, 0, vec(C_ERR, 1, S_ERR, 5));
        step("err_rst_cyc",  1, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ERR, 1, S_ERR, 6));
        step("err_cleared",  0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 0));

        // reset in MEM_WAIT with a simultaneous ack
        step("mw_enter",     0, 0, 0, 0, 0, 0, 1, 0, 0, vec(C_FRZ, 0, S_RUN, 0));
        step("mw_rst_ack",   1, 0, 0, 0, 0, 0, 1, 0, 1, vec(C_ADV_REQ, 0, S_MW, 1));
        step("mw_rst_done",  0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 0));

        // 20 consecutive load-use stalls saturate the 4-bit counter
        for (int i = 0; i < 20; i++) begin
            step("sat_stall", 0, 1, 9, 9, 0, 0, 0, 0, 0,
                 vec(C_LU, 0, S_RUN, (i > 15) ? 15 : i));
        end
        step("sat_hold",     0, 0, 0, 0, 0, 0, 0, 0, 0, vec(C_ADV, 0, S_RUN, 15));

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_stall_ctrl.md
Name: pipeline_stall_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage pipeline. It drives the write/bubble/flush controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It resolves three cases: load-use hazards, taken-branch flushes, and variable-latency data-memory accesses, using a req/ack handshake with a timeout. It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
MEM_TIMEOUT, 64, max cycles in MEM_WAIT without ack before entering ERROR (must be >=2)
CNT_W, 32, width of stall_cnt_o

Ports:
clk_i  input  1  clock, all state updates on posedge
rst_i  input  1  synchronous reset, active-high
IDEX_MemRead_i  input  1  instruction in EX is a load
IDEX_RDaddr_i  input  5  destination register of instruction in EX
IFID_RS1addr_i  input  5  rs1 of instruction in ID
IFID_RS2addr_i  input  5  rs2 of instruction in ID
Branch_taken_i  input  1  branch in ID resolved taken this cycle
EXMEM_MemRead_i  input  1  instruction in MEM is a load
EXMEM_MemWrite_i  input  1  instruction in MEM is a store
mem_ack_i  input  1  data memory completes the access this cycle
mem_req_o  output  1  data memory request
PCWrite_o  output  1  PC update enable
IFID_Write_o  output  1  IF/ID load enable
IFID_Flush_o  output  1  IF/ID loads NOP
IDEX_Bubble_o  output  1  ID/EX loads NOP (control bits zeroed)
EXMEM_Write_o  output  1  EX/MEM load enable
MEMWB_Write_o  output  1  MEM/WB load enable
MEMWB_Bubble_o  output  1  MEM/WB loads RegWrite=0, MemtoReg=0
mem_err_o  output  1  sticky memory-timeout flag
stall_cnt_o  output  CNT_W  saturating count of stalled cycles

Behaviour:
- State register: RUN, MEM_WAIT, ERROR. Reset gives state=RUN, timeout counter=0, mem_err_o=0, stall_cnt_o=0. All other outputs are combinational from state and inputs, so after reset they follow the RUN rules.
- mem_access = EXMEM_MemRead_i | EXMEM_MemWrite_i.
- loaduse = IDEX_MemRead_i & (IDEX_RDaddr_i!=0) & (IDEX_RDaddr_i==IFID_RS1addr_i | IDEX_RDaddr_i==IFID_RS2addr_i).
- RUN, no mem_access, or mem_access with mem_ack_i=1 (zero-wait access):
  - All enables =1 and MEMWB_Bubble_o=0.
  - mem_req_o = mem_access.
  - If loaduse: PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1, IFID_Flush_o=0. The branch is re-evaluated next cycle.
  - Else if Branch_taken_i: IFID_Flush_o=1, IDEX_Bubble_o=0.
  - Else both are 0.
- RUN, mem_access with mem_ack_i=0:
  - mem_req_o=1.
  - PCWrite_o, IFID_Write_o, EXMEM_Write_o = 0. The whole front end freezes.
  - MEMWB_Write_o=1 with MEMWB_Bubble_o=1.
  - IDEX_Bubble_o=0, IFID_Flush_o=0. The memory stall overrides loaduse and branch.
  - Next state MEM_WAIT, timeout counter <= 1.
- MEM_WAIT:
  - mem_req_o held at 1 continuously. Freeze as above, MEMWB bubbled.
  - On mem_ack_i=1: outputs for that cycle are exactly the RUN zero-wait rules, using the current loaduse and Branch_taken_i. MEM/WB captures the read data, pipeline advances, next state RUN, counter <= 0.
  - Else, if counter == MEM_TIMEOUT-1: next state ERROR and mem_err_o <= 1.
  - Else counter increments.
- ERROR: every enable =0, MEMWB_Bubble_o=1, mem_req_o=0, IDEX_Bubble_o=0, IFID_Flush_o=0. The state is left only by rst_i.
- stall_cnt_o increments by 1 on every cycle where PCWrite_o=0 (load-use, memory freeze, or ERROR). It saturates at all-ones and never wraps.
- Write to x0 never produces a load-use stall.
- rst_i asserted in any state, including mid-MEM_WAIT with a pending ack: next cycle is RUN with counters cleared and mem_err_o=0. mem_ack_i in the reset cycle is ignored.
- mem_ack_i arriving while in RUN with no mem_access is ignored.

Test Plan:
1. Reset then IDEX_MemRead_i=1, IDEX_RDaddr_i=5, IFID_RS2addr_i=5 for one cycle -> PCWrite_o=0, IFID_Write_o=0, IDEX_Bubble_o=1 that cycle; stall_cnt_o=1 next cycle. Repeat with RDaddr=0 -> no stall.
2. Branch_taken_i=1 with no hazard -> IFID_Flush_o=1, all enables 1. Same cycle with loaduse=1 -> IFID_Flush_o=0, IDEX_Bubble_o=1.
3. EXMEM_MemRead_i=1 with mem_ack_i=1 same cycle -> no stall, mem_req_o=1 for 1 cycle, state stays RUN.
4. Store with ack after 3 cycles -> 3 cycles of PCWrite_o=0, EXMEM_Write_o=0, MEMWB_Bubble_o=1, mem_req_o=1. On the ack cycle, MEMWB_Write_o=1, MEMWB_Bubble_o=0, PCWrite_o=1. stall_cnt_o=3.
5. MEM_TIMEOUT=4, load with no ack -> mem_err_o=1 after 4 stalled cycles, then all enables stay 0. Assert rst_i -> next cycle mem_err_o=0 and state RUN.
6. rst_i asserted in 2nd MEM_WAIT cycle with mem_ack_i=1 -> next cycle state RUN, stall_cnt_o=0, PCWrite_o=1. Preload stall_cnt to max (CNT_W=4, 20 stalls) -> stays at 15.
